// File: rtl/ascon_seq_ctrl_if.sv
// ============================================================================
// Module   : ascon_seq_ctrl_if
// Brief    : Host block-stream handshake between the host and the ASCON sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ascon_seq_ctrl_if;
    logic [63:0] blk_i;
    logic        blk_valid_i;
    logic        blk_ready_o;

    modport master (output blk_i, output blk_valid_i, input blk_ready_o);
    modport slave  (input blk_i, input blk_valid_i, output blk_ready_o);
endinterface

`default_nettype wire

// File: rtl/ascon_seq_ctrl.sv
// ============================================================================
// Module   : ascon_seq_ctrl
// Brief    : Sequences one ASCON AEAD message (init, AD blocks, PT blocks, tag) with watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ascon_seq_ctrl #(
    parameter int NB_AD   = 1,
    parameter int NB_PT   = 23,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    ascon_seq_ctrl_if.slave        host,
    output logic                   init_o,
    output logic                   associate_data_o,
    output logic                   finalisation_o,
    output logic                   data_valid_o,
    output logic [63:0]            data_o,
    input  logic                   end_initialisation_i,
    input  logic                   end_associate_i,
    input  logic                   cipher_valid_i,
    input  logic                   end_tag_i,
    input  logic [63:0]            cipher_i,
    input  logic [127:0]           tag_i,
    output logic [63:0]            cipher_o,
    output logic                   cipher_valid_o,
    output logic [127:0]           tag_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [7:0]             blk_idx_o
);

    localparam logic [7:0] C_LAST_AD = 8'(NB_AD - 1);
    localparam logic [7:0] C_LAST_PT = 8'(NB_PT - 1);
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_WAIT_INIT = 4'd2,
        S_AD_REQ    = 4'd3,
        S_AD_WAIT   = 4'd4,
        S_PT_REQ    = 4'd5,
        S_PT_WAIT   = 4'd6,
        S_TAG_WAIT  = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     idx_q, idx_d;
    logic [7:0]     wd_q, wd_d;
    logic [63:0]    data_q, cipher_q;
    logic [127:0]   tag_q;
    logic           dv_q, ad_q, fin_q, cv_q;
    logic           w_req, w_xfer, w_waiting;
    logic           w_load_blk, w_load_ct, w_load_tag, w_timeout;

    assign w_req     = (state_q == S_AD_REQ) || (state_q == S_PT_REQ);
    assign w_xfer    = w_req && host.blk_valid_i;
    assign w_waiting = (state_q == S_WAIT_INIT) || (state_q == S_AD_WAIT) ||
                       (state_q == S_PT_WAIT)   || (state_q == S_TAG_WAIT);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        w_load_blk = 1'b0;
        w_load_ct  = 1'b0;
        w_load_tag = 1'b0;
        w_timeout  = 1'b0;
        case (state_q)
            S_IDLE:      if (start_i) state_d = S_INIT;
            S_INIT:      state_d = S_WAIT_INIT;
            S_WAIT_INIT: if (end_initialisation_i) begin
                state_d = S_AD_REQ;
                idx_d   = 8'd0;
            end
            S_AD_REQ:    if (w_xfer) begin
                w_load_blk = 1'b1;
                state_d    = S_AD_WAIT;
            end
            S_AD_WAIT:   if (end_associate_i) begin
                if (idx_q < C_LAST_AD) begin
                    state_d = S_AD_REQ;
                    idx_d   = idx_q + 8'd1;
                end else begin
                    state_d = S_PT_REQ;
                    idx_d   = 8'd0;
                end
            end
            S_PT_REQ:    if (w_xfer) begin
                w_load_blk = 1'b1;
                state_d    = S_PT_WAIT;
            end
            S_PT_WAIT:   if (cipher_valid_i) begin
                w_load_ct = 1'b1;
                if (idx_q != C_LAST_PT) begin
                    state_d = S_PT_REQ;
                    idx_d   = idx_q + 8'd1;
                end else if (end_tag_i) begin
                    // Core may deliver the last ciphertext and the tag together
                    w_load_tag = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_TAG_WAIT;
                end
            end
            S_TAG_WAIT:  if (end_tag_i) begin
                w_load_tag = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // A completion event in the same cycle wins over the watchdog
        if (w_waiting && (state_d == state_q) && (wd_q == C_TIMEOUT)) begin
            w_timeout = 1'b1;
            state_d   = S_IDLE;
        end
        wd_d = (w_waiting && (state_d == state_q)) ? wd_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            wd_q     <= 8'd0;
            data_q   <= 64'd0;
            cipher_q <= 64'd0;
            tag_q    <= 128'd0;
            dv_q     <= 1'b0;
            ad_q     <= 1'b0;
            fin_q    <= 1'b0;
            cv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            dv_q    <= w_load_blk;
            ad_q    <= w_load_blk && (state_q == S_AD_REQ);
            fin_q   <= w_load_blk && (state_q == S_PT_REQ) && (idx_q == C_LAST_PT);
            cv_q    <= w_load_ct;
            if (w_load_blk) data_q   <= host.blk_i;
            if (w_load_ct)  cipher_q <= cipher_i;
            if (w_load_tag) tag_q    <= tag_i;
        end
    end

    assign host.blk_ready_o = w_req;
    assign init_o           = (state_q == S_INIT);
    assign associate_data_o = ad_q;
    assign finalisation_o   = fin_q;
    assign data_valid_o     = dv_q;
    assign data_o           = data_q;
    assign cipher_o         = cipher_q;
    assign cipher_valid_o   = cv_q;
    assign tag_o            = tag_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign error_o          = w_timeout;
    assign blk_idx_o        = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_seq_ctrl.sv
// ============================================================================
// Module   : tb_ascon_seq_ctrl
// Brief    : Self-checking bench for ascon_seq_ctrl with a behavioural ASCON core model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ascon_seq_ctrl;

    localparam int NB_AD   = 1;
    localparam int NB_PT   = 23;
    localparam int TIMEOUT = 255;
    localparam int NTOT    = NB_AD + NB_PT;
    localparam logic [127:0] KEY   = 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF;
    localparam logic [127:0] NONCE = 128'h4ED0EC0B98C529B7C8CDDF37BCD0284A;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic init_o, ad_o, fin_o, dv_o, cv_o, busy_o, done_o, error_o;
    logic [63:0]  data_o, cipher_o;
    logic [127:0] tag_o;
    logic [7:0]   blk_idx_o;
    logic c_end_init = 1'b0, c_end_ad = 1'b0, c_cv = 1'b0, c_end_tag = 1'b0;
    logic [63:0]  c_cipher = '0;
    logic [127:0] c_tag = '0;
    logic spur_tag = 1'b0, core_mute_init = 1'b0, tag_mode = 1'b0, mon_clr = 1'b0;
    logic end_tag_in;

    int n_tests = 0, n_fail = 0;
    int n_init, n_ad, n_pt, n_fin, fin_at, n_cv, n_done, n_err;
    logic [63:0] got_ct [NB_PT+4];
    logic [63:0] msg [NTOT];
    logic snap_busy, snap_ready;
    logic [7:0] snap_idx;
    int unsigned rst_cnt = 0;

    ascon_seq_ctrl_if hif ();

    assign end_tag_in = c_end_tag | spur_tag;

    ascon_seq_ctrl #(.NB_AD(NB_AD), .NB_PT(NB_PT), .TIMEOUT(TIMEOUT)) dut (
        .clock_i(clk), .reset_i(rst_n), .start_i(start), .host(hif),
        .init_o(init_o), .associate_data_o(ad_o), .finalisation_o(fin_o),
        .data_valid_o(dv_o), .data_o(data_o),
        .end_initialisation_i(c_end_init), .end_associate_i(c_end_ad),
        .cipher_valid_i(c_cv), .end_tag_i(end_tag_in),
        .cipher_i(c_cipher), .tag_i(c_tag),
        .cipher_o(cipher_o), .cipher_valid_o(cv_o), .tag_o(tag_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .blk_idx_o(blk_idx_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ks(input int j);
        return KEY[63:0] ^ NONCE[127:64] ^ (64'h9E3779B97F4A7C15 * 64'(j + 1));
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] a, input logic [63:0] x);
        return {a[126:0], a[127]} ^ {x, ~x};
    endfunction

    // Expected tag of the whole message in msg[], computed in one pass
    function automatic logic [127:0] ref_tag();
        logic [127:0] a;
        a = KEY ^ NONCE;
        for (int i = 0; i < NB_AD; i++) a = mix(a, msg[i]);
        for (int i = 0; i < NB_PT; i++) a = mix(a, msg[NB_AD+i] ^ ks(i));
        return a ^ KEY;
    endfunction

    function automatic int ct_errors();
        int e;
        e = 0;
        for (int j = 0; j < NB_PT; j++)
            if (got_ct[j] !== (msg[NB_AD+j] ^ ks(j))) e++;
        return e;
    endfunction

    always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_init <= 0; n_ad <= 0; n_pt <= 0; n_fin <= 0; fin_at <= -1;
            n_cv <= 0; n_done <= 0; n_err <= 0;
        end else begin
            if (init_o) n_init <= n_init + 1;
            if (dv_o && ad_o) n_ad <= n_ad + 1;
            if (dv_o && !ad_o) begin
                n_pt <= n_pt + 1;
                if (fin_o) begin n_fin <= n_fin + 1; fin_at <= n_pt; end
            end
            if (cv_o) begin
                if (n_cv < NB_PT + 4) got_ct[n_cv] <= cipher_o;
                n_cv <= n_cv + 1;
            end
            if (done_o)  n_done <= n_done + 1;
            if (error_o) n_err <= n_err + 1;
        end
    end

    initial begin : core_model
        logic [127:0] acc;
        logic [63:0]  ct;
        int           pidx;
        int unsigned  gen;
        bit           fin;
        acc = '0; ct = '0; pidx = 0; gen = 0; fin = 0;
        forever begin
            @(posedge clk); #1;
            gen = rst_cnt;
            if (!rst_n) continue;
            if (init_o) begin
                acc = KEY ^ NONCE; pidx = 0;
                if (!core_mute_init) begin
                    repeat ($urandom_range(1, 4)) @(posedge clk); #1;
                    if (rst_n && rst_cnt == gen) begin
                        c_end_init = 1'b1; @(posedge clk); #1; c_end_init = 1'b0;
                    end
                end
            end else if (dv_o && ad_o) begin
                acc = mix(acc, data_o);
                repeat ($urandom_range(1, 4)) @(posedge clk); #1;
                if (rst_n && rst_cnt == gen) begin
                    c_end_ad = 1'b1; @(posedge clk); #1; c_end_ad = 1'b0;
                end
            end else if (dv_o) begin
                ct = data_o ^ ks(pidx); pidx++; acc = mix(acc, ct); fin = fin_o;
                repeat ($urandom_range(1, 4)) @(posedge clk); #1;
                if (rst_n && rst_cnt == gen) begin
                    c_cipher = ct; c_cv = 1'b1;
                    if (fin && tag_mode) begin c_tag = acc ^ KEY; c_end_tag = 1'b1; end
                    @(posedge clk); #1; c_cv = 1'b0; c_end_tag = 1'b0;
                    if (fin && !tag_mode) begin
                        repeat ($urandom_range(1, 4)) @(posedge clk); #1;
                        if (rst_n && rst_cnt == gen) begin
                            c_tag = acc ^ KEY; c_end_tag = 1'b1;
                            @(posedge clk); #1; c_end_tag = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1; @(negedge clk); @(negedge clk); mon_clr = 1'b0;
    endtask

    // Host driver: one full message with optional stall, spurious events or mid-message reset
    task automatic run_msg(input int stall_k, input int stall_len, input bit spur, input int rst_k,
                           output int idx_bad, output bit to_flag);
        int n;
        idx_bad = 0; to_flag = 0;
        for (int i = 0; i < NTOT; i++) msg[i] = {$urandom, $urandom};
        clear_mon();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < NTOT && !to_flag; k++) begin
            if (k == stall_k) begin
                repeat (stall_len) @(posedge clk);
                @(negedge clk);
                snap_busy = busy_o; snap_ready = hif.blk_ready_o; snap_idx = blk_idx_o;
                @(posedge clk); #1;
            end else begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            hif.blk_i = msg[k]; hif.blk_valid_i = 1'b1;
            n = 0;
            @(negedge clk);
            while (!hif.blk_ready_o && n < 300) begin n++; @(negedge clk); end
            if (!hif.blk_ready_o) to_flag = 1;
            else if (blk_idx_o !== 8'(k < NB_AD ? k : k - NB_AD)) idx_bad++;
            @(posedge clk); #1;
            hif.blk_valid_i = 1'b0;
            if (spur && k == NB_AD - 1) begin
                start = 1'b1; spur_tag = 1'b1;
                @(posedge clk); #1; start = 1'b0; spur_tag = 1'b0;
            end
            if (k == rst_k) begin
                @(negedge clk); rst_n = 1'b0;
                return;
            end
        end
        n = 0;
        while (n_done == 0 && n_err == 0 && n < 1000) begin @(negedge clk); n++; end
        if (n_done == 0) to_flag = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [338:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        v = {init_o, ad_o, fin_o, dv_o, data_o, cipher_o, cv_o, tag_o, busy_o, done_o,
             error_o, blk_idx_o, hif.blk_ready_o};
        n_tests++;
        if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", v); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_message();
        int ib; bit to; int e;
        tag_mode = 1'b0;
        run_msg(-1, 0, 0, -1, ib, to);
        e = ct_errors();
        n_tests++; if (to) begin n_fail++; $display("FAIL full_timeout: got 1 expected 0"); end
        n_tests++; if (n_init != 1) begin n_fail++; $display("FAIL full_init: got %0d expected 1", n_init); end
        n_tests++; if (n_ad != NB_AD) begin n_fail++; $display("FAIL full_ad: got %0d expected %0d", n_ad, NB_AD); end
        n_tests++; if (n_pt != NB_PT) begin n_fail++; $display("FAIL full_dv: got %0d expected %0d", n_pt, NB_PT); end
        n_tests++; if (n_fin != 1 || fin_at != NB_PT - 1) begin
            n_fail++; $display("FAIL full_fin: got count %0d at %0d expected 1 at %0d", n_fin, fin_at, NB_PT - 1); end
        n_tests++; if (n_cv != NB_PT) begin n_fail++; $display("FAIL full_cv: got %0d expected %0d", n_cv, NB_PT); end
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL full_cipher: got %0d bad blocks expected 0", e); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL full_done: got %0d expected 1", n_done); end
        n_tests++; if (tag_o !== ref_tag()) begin n_fail++; $display("FAIL full_tag: got %h expected %h", tag_o, ref_tag()); end
        n_tests++; if (ib != 0) begin n_fail++; $display("FAIL full_idx: got %0d bad indices expected 0", ib); end
        n_tests++; if (busy_o !== 1'b0 || n_err != 0) begin
            n_fail++; $display("FAIL full_idle: got busy %b err %0d expected 0 0", busy_o, n_err); end
    endtask

    task automatic test_same_cycle_tag();
        int ib; bit to; int e;
        tag_mode = 1'b1;
        run_msg(-1, 0, 0, -1, ib, to);
        tag_mode = 1'b0;
        e = ct_errors();
        n_tests++; if (to || n_done != 1) begin n_fail++; $display("FAIL same_done: got %0d expected 1", n_done); end
        n_tests++; if (tag_o !== ref_tag()) begin n_fail++; $display("FAIL same_tag: got %h expected %h", tag_o, ref_tag()); end
        n_tests++; if (n_cv != NB_PT || e != 0) begin
            n_fail++; $display("FAIL same_cipher: got %0d strobes %0d bad expected %0d 0", n_cv, e, NB_PT); end
    endtask

    task automatic test_back_to_back();
        int ib; bit to;
        for (int m = 0; m < 2; m++) begin
            run_msg(-1, 0, 0, -1, ib, to);
            n_tests++;
            if (to || n_done != 1 || tag_o !== ref_tag()) begin
                n_fail++; $display("FAIL b2b_tag%0d: got %h done %0d expected %h done 1", m, tag_o, n_done, ref_tag()); end
        end
    endtask

    task automatic test_timeout();
        int c; logic [127:0] prev;
        prev = ref_tag();
        core_mute_init = 1'b1;
        clear_mon();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        c = 0;
        while (!error_o && c < 400) begin @(negedge clk); c++; end
        n_tests++; if (c != TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", c, TIMEOUT + 1); end
        @(negedge clk);
        n_tests++; if (busy_o !== 1'b0 || error_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: got busy %b err %b expected 0 0", busy_o, error_o); end
        n_tests++; if (n_err != 1 || n_done != 0) begin
            n_fail++; $display("FAIL timeout_pulses: got err %0d done %0d expected 1 0", n_err, n_done); end
        n_tests++; if (tag_o !== prev) begin n_fail++; $display("FAIL timeout_tag: got %h expected %h", tag_o, prev); end
        core_mute_init = 1'b0;
    endtask

    task automatic test_stall();
        int ib; bit to;
        run_msg(NB_AD + 5, 1000, 0, -1, ib, to);
        n_tests++; if ({snap_busy, snap_ready, snap_idx} !== {1'b1, 1'b1, 8'd5}) begin
            n_fail++; $display("FAIL stall_state: got busy %b ready %b idx %0d expected 1 1 5", snap_busy, snap_ready, snap_idx); end
        n_tests++; if (n_err != 0) begin n_fail++; $display("FAIL stall_error: got %0d expected 0", n_err); end
        n_tests++; if (to || tag_o !== ref_tag()) begin n_fail++; $display("FAIL stall_tag: got %h expected %h", tag_o, ref_tag()); end
    endtask

    task automatic test_reset_mid();
        int ib; bit to; int e;
        logic [338:0] v;
        run_msg(-1, 0, 0, NB_AD + 10, ib, to);
        #1;
        v = {init_o, ad_o, fin_o, dv_o, data_o, cipher_o, cv_o, tag_o, busy_o, done_o,
             error_o, blk_idx_o, hif.blk_ready_o};
        n_tests++; if (to || v !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 0", v); end
        n_tests++; if (n_done != 0 || n_err != 0) begin
            n_fail++; $display("FAIL midrst_pulses: got done %0d err %0d expected 0 0", n_done, n_err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_msg(-1, 0, 0, -1, ib, to);
        e = ct_errors();
        n_tests++; if (to || n_done != 1 || tag_o !== ref_tag() || e != 0) begin
            n_fail++; $display("FAIL midrst_restart: got tag %h done %0d bad %0d expected %h 1 0", tag_o, n_done, e, ref_tag()); end
    endtask

    task automatic test_spurious();
        int ib; bit to; int e;
        run_msg(-1, 0, 1, -1, ib, to);
        e = ct_errors();
        n_tests++; if (n_init != 1) begin n_fail++; $display("FAIL spur_init: got %0d expected 1", n_init); end
        n_tests++; if (to || n_done != 1 || n_cv != NB_PT || e != 0) begin
            n_fail++; $display("FAIL spur_flow: got done %0d cv %0d bad %0d expected 1 %0d 0", n_done, n_cv, e, NB_PT); end
        n_tests++; if (tag_o !== ref_tag()) begin n_fail++; $display("FAIL spur_tag: got %h expected %h", tag_o, ref_tag()); end
    endtask

    initial begin
        hif.blk_i = '0;
        hif.blk_valid_i = 1'b0;
        test_reset();
        test_full_message();
        test_same_cycle_tag();
        test_back_to_back();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ascon_seq_ctrl.md
ASCON_SEQ_CTRL -- requirements
Module: ascon_seq_ctrl

Interface
REQ-001 Parameter NB_AD, default 1, number of 64-bit associated-data blocks per message (range 1..15).
REQ-002 Parameter NB_PT, default 23, number of 64-bit plaintext blocks per message (range 1..255).
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for any core completion flag.
REQ-004 clock_i  in  1  single system clock, rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  one-cycle pulse that starts one message; ignored unless idle.
REQ-007 blk_i  in  64  host block (AD first, then PT).
REQ-008 blk_valid_i  in  1  host block valid.
REQ-009 blk_ready_o  out  1  controller accepts blk_i; transfer when blk_valid_i & blk_ready_o.
REQ-010 init_o, associate_data_o, finalisation_o, data_valid_o  out  1 each  ASCON core controls.
REQ-011 data_o  out  64  block to core, registered.
REQ-012 end_initialisation_i, end_associate_i, cipher_valid_i, end_tag_i  in  1 each  core status pulses.
REQ-013 cipher_i  in  64 / tag_i  in  128  core results.
REQ-014 cipher_o  out  64 / cipher_valid_o  out  1  captured ciphertext block and one-cycle strobe.
REQ-015 tag_o  out  128  captured tag, held until next start.
REQ-016 busy_o, done_o, error_o  out  1  busy level; done and error one-cycle pulses.
REQ-017 blk_idx_o  out  8  index of current block within its phase (0-based).

Function
REQ-018 FSM states: IDLE, INIT, WAIT_INIT, AD_REQ, AD_WAIT, PT_REQ, PT_WAIT, TAG_WAIT, DONE.
REQ-019 IDLE --start_i--> INIT; INIT drives init_o=1 for exactly one cycle, then WAIT_INIT.
REQ-020 WAIT_INIT --end_initialisation_i--> AD_REQ with blk_idx cleared to 0.
REQ-021 AD_REQ: blk_ready_o=1; on transfer, register data_o=blk_i and in the next cycle pulse data_valid_o=1 and associate_data_o=1 for one cycle, then AD_WAIT.
REQ-022 AD_WAIT --end_associate_i--> AD_REQ with blk_idx+1 if blk_idx<NB_AD-1, else PT_REQ with blk_idx=0.
REQ-023 PT_REQ: blk_ready_o=1; on transfer, pulse data_valid_o one cycle later; for blk_idx=NB_PT-1 also pulse finalisation_o in that same cycle; then PT_WAIT.
REQ-024 PT_WAIT --cipher_valid_i--> capture cipher_i into cipher_o and pulse cipher_valid_o next cycle; then PT_REQ (blk_idx+1) if not last block, else TAG_WAIT.
REQ-025 TAG_WAIT --end_tag_i--> capture tag_i into tag_o, go to DONE; DONE pulses done_o one cycle, returns to IDLE.
REQ-026 blk_ready_o=1 only in AD_REQ/PT_REQ; core controls are never asserted in any other state.
REQ-027 busy_o=1 in every state except IDLE.
REQ-028 Watchdog: 8-bit counter cleared on each state entry, increments in WAIT_INIT/AD_WAIT/PT_WAIT/TAG_WAIT; reaching TIMEOUT pulses error_o one cycle and returns to IDLE; tag_o unchanged.
REQ-029 A core status pulse arriving in a state not waiting for it is ignored.
REQ-030 cipher_valid_i and end_tag_i in the same cycle on the last block: capture both, go directly to DONE.
REQ-031 start_i while busy_o=1 is ignored; host stalls (blk_valid_i=0) in request states indefinitely without watchdog.
REQ-032 blk_idx_o wraps never: exceeding NB_PT-1 is unreachable by construction.

Reset
REQ-033 reset_i low forces IDLE immediately; all outputs 0 (data_o, cipher_o, tag_o, blk_idx_o zeroed), watchdog cleared.
REQ-034 Reset mid-message aborts without done_o or error_o; next start_i begins a fresh message.

Verification
REQ-035 NB_AD=1, NB_PT=23, behavioural core model, key 8A55114D1CB6A9A2BE263D4D7AECAAFF, nonce 4ED0EC0B98C529B7C8CDDF37BCD0284A -> 1 init, 1 AD, 23 data_valid, finalisation_o only on block 22, 23 cipher_valid_o, done_o once, tag_o equals model tag.
REQ-036 Core never asserts end_initialisation_i, TIMEOUT=255 -> error_o after 255 cycles in WAIT_INIT, busy_o=0 next cycle.
REQ-037 Host holds blk_valid_i=0 for 1000 cycles in PT_REQ -> no error_o, state held, completes normally afterwards.
REQ-038 reset_i low during PT_WAIT of block 10 -> all outputs 0 immediately; restart completes full message with correct tag.
REQ-039 start_i pulsed during AD_WAIT plus spurious end_tag_i in AD_WAIT -> both ignored, message completes unchanged.
